// File: rtl/jelly_fifo_burst_arbiter.sv
// Round-robin burst arbiter: grants one FIFO source a burst once it holds a full
// burst (or aged partial data), issues the command, then forwards exactly that many beats.
`timescale 1ns/1ps
module jelly_fifo_burst_arbiter #(
  parameter int N             = 4,
  parameter int ID_WIDTH      = 4,
  parameter int DATA_WIDTH    = 64,
  parameter int COUNT_WIDTH   = 9,
  parameter int LEN_WIDTH     = 8,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [LEN_WIDTH-1:0]       param_burst_len,
  input  logic [TIMEOUT_WIDTH-1:0]   param_timeout,
  input  logic [N*COUNT_WIDTH-1:0]   s_count,
  input  logic [N*DATA_WIDTH-1:0]    s_data,
  input  logic [N-1:0]               s_valid,
  output logic [N-1:0]               s_ready,
  output logic [ID_WIDTH-1:0]        m_cmd_id,
  output logic [LEN_WIDTH-1:0]       m_cmd_len,
  output logic                       m_cmd_valid,
  input  logic                       m_cmd_ready,
  output logic [ID_WIDTH-1:0]        m_id,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_last,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic                       busy
);

  localparam int CMPW = (COUNT_WIDTH > LEN_WIDTH) ? COUNT_WIDTH : LEN_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                     state_q, state_d;
  logic [ID_WIDTH-1:0]        rr_q, rr_d;
  logic [ID_WIDTH-1:0]        grant_q, grant_d;
  logic [LEN_WIDTH-1:0]       len_q, len_d;
  logic [LEN_WIDTH-1:0]       beat_q, beat_d;
  logic [TIMEOUT_WIDTH-1:0]   timer_q [N];
  logic [TIMEOUT_WIDTH-1:0]   timer_d [N];

  logic [COUNT_WIDTH-1:0]     cnt [N];
  logic [LEN_WIDTH-1:0]       eff_len;
  logic [N-1:0]               eligible;
  logic                       found;
  logic [ID_WIDTH-1:0]        pick;
  logic [COUNT_WIDTH-1:0]     pick_cnt;
  logic [LEN_WIDTH-1:0]       grant_len;
  logic                       grant_fire;
  int unsigned                idx;
  logic                       sel_valid;
  logic [DATA_WIDTH-1:0]      sel_data;
  logic                       in_data;
  logic                       beat_fire;

  always_comb begin
    eff_len = (param_burst_len == '0) ? LEN_WIDTH'(1) : param_burst_len;
    for (int unsigned i = 0; i < N; i++) begin
      cnt[i]      = s_count[i*COUNT_WIDTH +: COUNT_WIDTH];
      eligible[i] = (CMPW'(cnt[i]) >= CMPW'(eff_len)) ||
                    ((cnt[i] != '0) && (timer_q[i] >= param_timeout));
    end
  end

  // Search starts one past the last grant so the previous winner has lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = (32'(rr_q) + k) % N;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = ID_WIDTH'(idx);
      end
    end
    pick_cnt = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (pick == ID_WIDTH'(i)) pick_cnt = cnt[i];
    end
    grant_len  = (CMPW'(pick_cnt) >= CMPW'(eff_len)) ? eff_len : LEN_WIDTH'(pick_cnt);
    grant_fire = (state_q == ST_IDLE) && found;
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      if ((cnt[i] == '0) || (grant_fire && (pick == ID_WIDTH'(i)))) begin
        timer_d[i] = '0;
      end else if (timer_q[i] == '1) begin
        timer_d[i] = timer_q[i];
      end else begin
        timer_d[i] = timer_q[i] + TIMEOUT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_q == ID_WIDTH'(i)) begin
        sel_valid = s_valid[i];
        sel_data  = s_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    in_data   = (state_q == ST_DATA);
    beat_fire = in_data && sel_valid && m_ready;
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    len_d   = len_q;
    beat_d  = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = pick;
          len_d   = grant_len;
          rr_d    = pick;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (m_cmd_ready) begin
          beat_d  = len_q;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (beat_fire) begin
          if (beat_q == LEN_WIDTH'(1)) state_d = ST_IDLE;
          else                         beat_d  = beat_q - LEN_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      rr_q    <= ID_WIDTH'(N-1);
      grant_q <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      for (int unsigned i = 0; i < N; i++) timer_q[i] <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      for (int unsigned i = 0; i < N; i++) timer_q[i] <= timer_d[i];
    end
  end

  // Beat-side outputs are forced to zero outside DATA so a reset clears them at once.
  always_comb begin
    m_cmd_valid = (state_q == ST_CMD);
    m_cmd_id    = grant_q;
    m_cmd_len   = len_q;
    busy        = (state_q != ST_IDLE);
    m_valid     = in_data && sel_valid;
    m_data      = in_data ? sel_data : '0;
    m_id        = in_data ? grant_q : '0;
    m_last      = in_data && (beat_q == LEN_WIDTH'(1));
    for (int unsigned i = 0; i < N; i++) begin
      s_ready[i] = in_data && (grant_q == ID_WIDTH'(i)) && m_ready;
    end
  end

endmodule

// File: tb/tb_jelly_fifo_burst_arbiter.sv
// Directed bench for jelly_fifo_burst_arbiter: expected commands and beats are queued
// when a scenario is set up and compared as the arbiter emits them.
`timescale 1ns/1ps
module tb_jelly_fifo_burst_arbiter;
  localparam int N   = 4;
  localparam int IDW = 4;
  localparam int DW  = 64;
  localparam int CW  = 9;
  localparam int LW  = 8;
  localparam int TW  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [LW-1:0]     param_burst_len;
  logic [TW-1:0]     param_timeout;
  logic [N*CW-1:0]   s_count;
  logic [N*DW-1:0]   s_data;
  logic [N-1:0]      s_valid;
  logic [N-1:0]      s_ready;
  logic [IDW-1:0]    m_cmd_id;
  logic [LW-1:0]     m_cmd_len;
  logic              m_cmd_valid;
  logic              m_cmd_ready;
  logic [IDW-1:0]    m_id;
  logic [DW-1:0]     m_data;
  logic              m_last;
  logic              m_valid;
  logic              m_ready;
  logic              busy;

  always #5 clk = ~clk;

  jelly_fifo_burst_arbiter #(
    .N(N), .ID_WIDTH(IDW), .DATA_WIDTH(DW),
    .COUNT_WIDTH(CW), .LEN_WIDTH(LW), .TIMEOUT_WIDTH(TW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .param_burst_len(param_burst_len), .param_timeout(param_timeout),
    .s_count(s_count), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_cmd_id(m_cmd_id), .m_cmd_len(m_cmd_len), .m_cmd_valid(m_cmd_valid),
    .m_cmd_ready(m_cmd_ready),
    .m_id(m_id), .m_data(m_data), .m_last(m_last), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy)
  );

  typedef struct { logic [IDW-1:0] id; logic [LW-1:0] len; } cmd_t;
  typedef struct { logic [IDW-1:0] id; logic [DW-1:0] data; logic last; } beat_t;

  cmd_t        cmd_q[$];
  beat_t       beat_q[$];
  logic [31:0] exp_next [N];
  logic [31:0] seq [N];
  int          vectors = 0;
  int          errors  = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] outs();
    return 128'({m_cmd_valid, busy, m_valid, m_last, s_ready, m_cmd_id, m_cmd_len, m_id, m_data});
  endfunction

  // Source model: each source streams {id, sequence}; sequence advances on a handshake.
  initial begin
    logic [N-1:0] hs;
    for (int i = 0; i < N; i++) seq[i] = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) s_data[i*DW +: DW] = {32'(i), seq[i]};
      #2;
      hs = s_valid & s_ready;
      @(posedge clk);
      for (int i = 0; i < N; i++) if (hs[i]) seq[i] = seq[i] + 32'd1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic set_count(input int i, input int v);
    s_count[i*CW +: CW] = CW'(v);
  endtask

  task automatic push(input int id, input int len);
    cmd_t  c;
    beat_t b;
    c.id = IDW'(id);
    c.len = LW'(len);
    cmd_q.push_back(c);
    for (int j = 0; j < len; j++) begin
      b.id   = IDW'(id);
      b.data = {32'(id), exp_next[id]};
      b.last = (j == len - 1);
      beat_q.push_back(b);
      exp_next[id] = exp_next[id] + 32'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    m_cmd_ready = 1'b0;
    m_ready = 1'b0;
    s_valid = '0;
    s_count = '0;
    #1;
    check("reset_outputs", outs(), 128'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cmd_q.delete();
    beat_q.delete();
  endtask

  task automatic wait_cmd(output bit got);
    got = 1'b0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      m_cmd_ready = 1'b0;
      #1;
      if (m_cmd_valid === 1'b1) got = 1'b1;
    end
  endtask

  task automatic run_burst(input bit rnd, input int stall);
    cmd_t  c;
    beat_t b;
    bit    got;
    bit    done;
    c = cmd_q.pop_front();
    wait_cmd(got);
    check("cmd_valid_seen", 128'(got), 128'(1));
    if (!got) begin
      beat_q.delete();
      return;
    end
    check("cmd_fields", 128'({m_cmd_id, m_cmd_len}), 128'({c.id, c.len}));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      #1;
      check("cmd_stable", 128'({m_cmd_valid, m_cmd_id, m_cmd_len}), 128'({1'b1, c.id, c.len}));
    end
    @(negedge clk);
    m_cmd_ready = 1'b1;
    done = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      m_cmd_ready = 1'b0;
      m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_valid = rnd ? N'($urandom) : '1;
      #1;
      check("other_ready_low", 128'(s_ready & ~(N'(1) << c.id)), 128'(0));
      if (m_valid === 1'b1 && m_ready) begin
        b = beat_q.pop_front();
        check("beat", 128'({m_id, m_last, m_data}), 128'({b.id, b.last, b.data}));
        done = b.last;
      end
    end
    check("burst_done", 128'(done), 128'(1));
  endtask

  initial begin
    bit got;
    bit early;
    reset_n = 1'b0;
    param_burst_len = '0;
    param_timeout = '0;
    s_count = '0;
    s_valid = '0;
    m_cmd_ready = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < N; i++) exp_next[i] = '0;

    // single full burst from source 0, then nothing further
    do_reset();
    param_burst_len = 8'd16;
    param_timeout = 16'd1000;
    set_count(0, 16);
    push(0, 16);
    run_burst(1'b0, 0);
    s_count = '0;
    early = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (m_cmd_valid !== 1'b0 || busy !== 1'b0) early = 1'b1;
    end
    check("idle_after_burst", 128'(early), 128'(0));

    // round robin over all sources
    do_reset();
    param_burst_len = 8'd8;
    param_timeout = 16'd1000;
    for (int i = 0; i < N; i++) set_count(i, 32);
    push(0, 8); push(1, 8); push(2, 8); push(3, 8); push(0, 8);
    for (int k = 0; k < 5; k++) run_burst(1'b0, 0);
    s_count = '0;

    // partial burst becomes eligible only after the timeout
    do_reset();
    param_burst_len = 8'd16;
    param_timeout = 16'd50;
    @(negedge clk);
    set_count(2, 3);
    early = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (m_cmd_valid !== 1'b0) early = 1'b1;
    end
    check("timeout_hold", 128'(early), 128'(0));
    @(negedge clk);
    #1;
    check("timeout_grant", 128'(m_cmd_valid), 128'(1));
    push(2, 3);
    run_burst(1'b0, 0);
    s_count = '0;

    // stalled command and random flow control
    do_reset();
    param_burst_len = 8'd8;
    param_timeout = 16'd1000;
    set_count(1, 20);
    set_count(3, 20);
    push(1, 8);
    push(3, 8);
    run_burst(1'b1, 5);
    run_burst(1'b1, 5);
    s_count = '0;

    // zero burst length behaves as one
    do_reset();
    param_burst_len = 8'd0;
    param_timeout = 16'd1000;
    set_count(1, 1);
    push(1, 1);
    run_burst(1'b0, 0);
    s_count = '0;

    // reset in the middle of a burst
    do_reset();
    param_burst_len = 8'd8;
    param_timeout = 16'd1000;
    set_count(2, 20);
    wait_cmd(got);
    check("abort_cmd_seen", 128'({got, m_cmd_id}), 128'({1'b1, 4'd2}));
    @(negedge clk);
    m_cmd_ready = 1'b1;
    @(negedge clk);
    m_cmd_ready = 1'b0;
    m_ready = 1'b1;
    s_valid = '1;
    repeat (3) @(negedge clk);
    #1;
    check("abort_in_data", 128'({busy, m_valid}), 128'({1'b1, 1'b1}));
    @(negedge clk);
    reset_n = 1'b0;
    set_count(1, 20);
    set_count(3, 20);
    #1;
    check("abort_outputs_zero", outs(), 128'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_ready = 1'b0;
    push(1, 8);
    run_burst(1'b0, 0);
    s_count = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
